count_decode: RTL



---
 rtl/count_decode_pkg.sv | 22 ++
 rtl/count_decode_if.sv | 42 ++++
 rtl/count_decode_step_classify.sv | 29 ++
 rtl/count_decode.sv | 124 ++++++++++++
 4 files changed

// File: rtl/count_decode_pkg.sv
// count_decode_pkg: shared types and defaults for the count_decode observer.
// FSM state encodings are plain localparams; the step command is an enum so
// a future stimulus generator can reuse count_step_classify directly.
package count_decode_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int RUN_W_DEF = 8;

    // Decoder FSM states (exposed on state_dbg)
    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    // Classified step between two consecutive samples
    typedef enum logic [1:0] {
        CMD_HOLD    = 2'd0,
        CMD_UP      = 2'd1,
        CMD_DOWN    = 2'd2,
        CMD_ILLEGAL = 2'd3
    } cmd_t;

endpackage

// File: rtl/count_decode_if.sv
// count_decode_if: observed count bus plus decoded result bus.
// Optional macro COUNT_DECODE_WRAP_STATS_EN adds the wrap counters.
//
// Handshake: en acts as the valid qualifier for cnt_in; the decoder has no
// backpressure (ready is implicitly always 1), so every edge with en=1
// consumes one sample. dec_valid qualifies dec_s0/dec_s1 for one cycle.
interface count_decode_if #(
    parameter int WIDTH = 8,
    parameter int RUN_W = 8
);
    logic             en;
    logic [WIDTH-1:0] cnt_in;
    logic             err_clr;
    logic             dec_valid;
    logic             dec_s0;
    logic             dec_s1;
    logic             err_pulse;
    logic             err_sticky;
    logic [RUN_W-1:0] run_len;
`ifdef COUNT_DECODE_WRAP_STATS_EN
    logic [15:0]      wrap_up_cnt;
    logic [15:0]      wrap_down_cnt;
`endif

    // Source side: drives samples, reads decode
    modport master (
        output en, cnt_in, err_clr,
        input  dec_valid, dec_s0, dec_s1, err_pulse, err_sticky, run_len
`ifdef COUNT_DECODE_WRAP_STATS_EN
        , input wrap_up_cnt, wrap_down_cnt
`endif
    );

    // Decoder side
    modport slave (
        input  en, cnt_in, err_clr,
        output dec_valid, dec_s0, dec_s1, err_pulse, err_sticky, run_len
`ifdef COUNT_DECODE_WRAP_STATS_EN
        , output wrap_up_cnt, wrap_down_cnt
`endif
    );
endinterface

// File: rtl/count_decode_step_classify.sv
// count_step_classify: combinational classification of one counter step.
// diff = cnt_in - prev (mod 2^WIDTH): 0 hold, 1 up, all-ones down, else illegal.
module count_step_classify
    import count_decode_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] cnt_in,
    input  logic [WIDTH-1:0] prev,
    output cmd_t             cmd
);
    localparam logic [WIDTH-1:0] DIFF_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] DIFF_MONE = '1;

    logic [WIDTH-1:0] diff;

    // Modular difference naturally handles the wrap in both directions
    always_comb begin
        diff = cnt_in - prev;
        if (diff == '0)
            cmd = CMD_HOLD;
        else if (diff == DIFF_ONE)
            cmd = CMD_UP;
        else if (diff == DIFF_MONE)
            cmd = CMD_DOWN;
        else
            cmd = CMD_ILLEGAL;
    end
endmodule

// File: rtl/count_decode.sv
// count_decode: observes an up/down counter's registered output and recovers
// the hold/up/down command stream, flags illegal steps and tracks run length.
// Optional macro COUNT_DECODE_WRAP_STATS_EN adds wrap_up_cnt/wrap_down_cnt.
module count_decode
    import count_decode_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int RUN_W = RUN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    count_decode_if.slave     bus,
    output logic [1:0]        state_dbg
);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_MAX = '1;

    logic [1:0]       state;
    logic [WIDTH-1:0] prev;
    cmd_t             step_cmd;
    cmd_t             last_cmd;
    logic             have_cmd;   // a legal decode exists since last SYNC
    logic             dec_valid_q;
    logic             s0_q;
    logic             s1_q;
    logic             pulse_q;
    logic             sticky_q;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_next;

    count_step_classify #(.WIDTH(WIDTH)) u_classify (
        .cnt_in (bus.cnt_in),
        .prev   (prev),
        .cmd    (step_cmd)
    );

    // Run length for a legal step: restart at 1 on a new command, else saturate
    always_comb begin
        run_next = RUN_ONE;
        if (have_cmd && (step_cmd == last_cmd))
            run_next = (run_q == RUN_MAX) ? run_q : run_q + RUN_ONE;
    end

    // Decoder FSM; err_clr is honoured even when en=0, errors beat err_clr
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_SYNC;
            prev        <= '0;
            last_cmd    <= CMD_HOLD;
            have_cmd    <= 1'b0;
            dec_valid_q <= 1'b0;
            s0_q        <= 1'b0;
            s1_q        <= 1'b0;
            pulse_q     <= 1'b0;
            sticky_q    <= 1'b0;
            run_q       <= '0;
        end else begin
            pulse_q     <= 1'b0;
            dec_valid_q <= 1'b0;
            if (bus.err_clr)
                sticky_q <= 1'b0;
            if ((state == ST_FAULT) && bus.err_clr) begin
                state <= ST_SYNC;
            end else if (bus.en) begin
                prev <= bus.cnt_in;
                case (state)
                    ST_SYNC: begin
                        run_q    <= '0;
                        have_cmd <= 1'b0;
                        state    <= ST_TRACK;
                    end
                    ST_TRACK: begin
                        if (step_cmd == CMD_ILLEGAL) begin
                            pulse_q  <= 1'b1;
                            sticky_q <= 1'b1;
                            run_q    <= '0;
                            have_cmd <= 1'b0;
                            state    <= ST_FAULT;
                        end else begin
                            dec_valid_q <= 1'b1;
                            s0_q        <= (step_cmd == CMD_HOLD);
                            s1_q        <= (step_cmd == CMD_UP);
                            run_q       <= run_next;
                            have_cmd    <= 1'b1;
                            last_cmd    <= step_cmd;
                        end
                    end
                    default: begin
                        // FAULT: only keep prev following the bus
                    end
                endcase
            end
        end
    end

`ifdef COUNT_DECODE_WRAP_STATS_EN
    logic [15:0] wrap_up_q;
    logic [15:0] wrap_down_q;

    // Count legal wraps through the all-ones/zero boundary, saturating
    always_ff @(posedge clk) begin
        if (rst || bus.err_clr) begin
            wrap_up_q   <= '0;
            wrap_down_q <= '0;
        end else if (bus.en && (state == ST_TRACK)) begin
            if ((step_cmd == CMD_UP) && (prev == '1) && (wrap_up_q != 16'hFFFF))
                wrap_up_q <= wrap_up_q + 16'd1;
            if ((step_cmd == CMD_DOWN) && (prev == '0) && (wrap_down_q != 16'hFFFF))
                wrap_down_q <= wrap_down_q + 16'd1;
        end
    end

    assign bus.wrap_up_cnt   = wrap_up_q;
    assign bus.wrap_down_cnt = wrap_down_q;
`endif

    assign bus.dec_valid  = dec_valid_q;
    assign bus.dec_s0     = s0_q;
    assign bus.dec_s1     = s1_q;
    assign bus.err_pulse  = pulse_q;
    assign bus.err_sticky = sticky_q;
    assign bus.run_len    = run_q;
    assign state_dbg      = state;
endmodule
